// File: rtl/game_tick_receiver_pkg.sv
// Shared game timebase definitions: receiver FSM encoding, sticky error bit positions, nominal frame timing.
// Also referenced by the game clock generator; no logic, no latency, no flow control.
package game_timing_pkg;

    localparam int FRAME_PERIOD_CYCLES = 965664;
    localparam int LEAD_NOM_DEFAULT    = 255;

    localparam int ERR_W         = 4;
    localparam int ERR_NO_EARLY  = 0;
    localparam int ERR_OVERRUN   = 1;
    localparam int ERR_DUP_EARLY = 2;
    localparam int ERR_LEAD      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREP   = 2'd1,
        ST_READY  = 2'd2,
        ST_COMMIT = 2'd3
    } tick_state_t;

endpackage

// File: rtl/game_tick_receiver_if.sv
// Frame pulse / prepare-commit handshake bundle between timebase, game logic and the tick receiver.
// Master drives pulses, ack and clear; slave (the receiver) returns registered status with no backpressure.
interface game_tick_receiver_if #(
    parameter int FRAME_W = 16,
    parameter int LEAD_W  = 10
);
    logic               pulse_early_in;
    logic               pulse_in;
    logic               prep_ack;
    logic               err_clr;
    logic               prep_req;
    logic               commit_stb;
    logic [FRAME_W-1:0] frame_count;
    logic [LEAD_W-1:0]  last_lead;
    logic               stalled;
    logic [3:0]         err;

    modport master (
        output pulse_early_in, pulse_in, prep_ack, err_clr,
        input  prep_req, commit_stb, frame_count, last_lead, stalled, err
    );

    modport slave (
        input  pulse_early_in, pulse_in, prep_ack, err_clr,
        output prep_req, commit_stb, frame_count, last_lead, stalled, err
    );
endinterface

// File: rtl/game_tick_receiver_watchdog.sv
// Saturating cycle counter with synchronous clear; expired is registered and high while the count sits at CYCLES.
// One cycle from clr to expired dropping; no backpressure.
module tick_watchdog #(
    parameter int unsigned CYCLES = 40
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic expired
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (cnt != CNT_MAX)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            expired <= (cnt_nxt == CNT_MAX);
        end
    end
endmodule

// File: rtl/game_tick_receiver.sv
// Frame tick consumer: early pulse requests prep, main pulse commits; counts frames, watchdog, sticky errors.
// All outputs registered, 1 cycle after the causing input; no backpressure. Lead check under GAME_TICK_RX_LEAD_CHECK_EN.
module game_tick_receiver
    import game_timing_pkg::*;
#(
    parameter int          FRAME_W     = 16,
    parameter int          LEAD_W      = 10,
    parameter int unsigned WDOG_CYCLES = 2 * FRAME_PERIOD_CYCLES,
    parameter int          LEAD_NOM    = LEAD_NOM_DEFAULT,
    parameter int          LEAD_TOL    = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    game_tick_receiver_if.slave  bus
);
    tick_state_t        state;
    tick_state_t        state_nxt;
    logic [ERR_W-1:0]   err_fsm;
    logic [ERR_W-1:0]   err_set;
    logic [ERR_W-1:0]   err_q;
    logic               commit_go;
    logic               lead_err;
    logic               prep_req_q;
    logic               commit_stb_q;
    logic               stalled_w;
    logic [FRAME_W-1:0] frame_count_q;

    // An early pulse in COMMIT opens the next frame straight away.
    always_comb begin
        state_nxt = state;
        err_fsm   = '0;
        commit_go = 1'b0;
        case (state)
            ST_IDLE, ST_COMMIT: begin
                state_nxt             = bus.pulse_early_in ? ST_PREP : ST_IDLE;
                err_fsm[ERR_NO_EARLY] = bus.pulse_in;
            end
            ST_PREP: begin
                if (bus.prep_ack && bus.pulse_in) begin
                    state_nxt = ST_COMMIT;
                    commit_go = 1'b1;
                end else if (bus.prep_ack) begin
                    state_nxt = ST_READY;
                end else begin
                    err_fsm[ERR_OVERRUN] = bus.pulse_in;
                end
                err_fsm[ERR_DUP_EARLY] = bus.pulse_early_in;
            end
            ST_READY: begin
                if (bus.pulse_in) begin
                    state_nxt = ST_COMMIT;
                    commit_go = 1'b1;
                end
                err_fsm[ERR_DUP_EARLY] = bus.pulse_early_in;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign err_set = err_fsm | (ERR_W'(lead_err) << ERR_LEAD);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= ST_IDLE;
            prep_req_q    <= 1'b0;
            commit_stb_q  <= 1'b0;
            frame_count_q <= '0;
            err_q         <= '0;
        end else begin
            state         <= state_nxt;
            prep_req_q    <= (state_nxt == ST_PREP);
            commit_stb_q  <= commit_go;
            frame_count_q <= frame_count_q + FRAME_W'(commit_go);
            err_q         <= (bus.err_clr ? '0 : err_q) | err_set;
        end
    end

    tick_watchdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (CLOCK_50),
        .reset   (reset),
        .clr     (bus.pulse_in),
        .expired (stalled_w)
    );

`ifdef GAME_TICK_RX_LEAD_CHECK_EN
    localparam logic [LEAD_W-1:0] LEAD_MAX = '1;

    logic [LEAD_W-1:0] lead_cnt;
    logic [LEAD_W-1:0] lead_meas;
    logic [LEAD_W-1:0] last_lead_q;
    int                lead_i;

    // lead_meas counts the main-pulse cycle itself, so early-to-main spacing N reads as N.
    assign lead_meas = (lead_cnt == LEAD_MAX) ? LEAD_MAX : lead_cnt + 1'b1;
    assign lead_i    = int'(lead_meas);
    assign lead_err  = commit_go &&
                       ((lead_i > LEAD_NOM + LEAD_TOL) || (lead_i < LEAD_NOM - LEAD_TOL));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            lead_cnt    <= '0;
            last_lead_q <= '0;
        end else begin
            lead_cnt <= bus.pulse_early_in ? '0 : lead_meas;
            if (commit_go)
                last_lead_q <= lead_meas;
        end
    end

    assign bus.last_lead = last_lead_q;
`else
    assign lead_err      = 1'b0;
    assign bus.last_lead = '0;
`endif

    assign bus.prep_req    = prep_req_q;
    assign bus.commit_stb  = commit_stb_q;
    assign bus.frame_count = frame_count_q;
    assign bus.stalled     = stalled_w;
    assign bus.err         = err_q;
endmodule
